// File: rtl/ahb_dphase_mux_pkg.sv
// Shared types and helpers for the AHB data-phase response multiplexer.
// Holds the data-phase state encoding, HRESP codes and the one-hot check.
package ahb_dphase_mux_pkg;

    typedef enum logic [1:0] {
        D_IDLE,
        D_SLV,
        D_ERR1,
        D_ERR2
    } dphase_state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // True when exactly one of the low n bits of v is set.
    function automatic logic is_onehot(logic [31:0] v, int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < n && v[i]) begin
                cnt++;
            end
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/ahb_dphase_mux_onehot_mux.sv
// AND-OR selector over CHANNEL_NUM inputs; yields zero unless the select is one-hot.
module ahb_onehot_mux
    import ahb_dphase_mux_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int WIDTH       = 34
) (
    input  logic [CHANNEL_NUM-1:0]            sel_i,
    input  logic [CHANNEL_NUM-1:0][WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]                  data_o
);

    always_comb begin
        data_o = '0;
        if (is_onehot(32'(sel_i), CHANNEL_NUM)) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (sel_i[i]) begin
                    data_o |= data_i[i];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_dphase_mux.sv
// AHB read-data/response mux: tracks the address-phase select into the data phase
// and answers unmapped or multi-hot selects with a built-in two-cycle ERROR slave.
module ahb_dphase_mux
    import ahb_dphase_mux_pkg::*;
#(
    parameter int CHANNEL_NUM = 4,
    parameter int PAYLOAD     = 34,
    parameter int REG_OUT     = 0
) (
    input  logic                              hclk,
    input  logic                              hreset,
    input  logic                              hready_in,
    input  logic                              htrans_valid,
    input  logic [CHANNEL_NUM-1:0]            sel_addr,
    input  logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in,
    input  logic [CHANNEL_NUM-1:0]            hreadyout_in,
    input  logic [CHANNEL_NUM-1:0]            hresp_in,
    output logic [PAYLOAD-1:0]                payload_out,
    output logic                              hready_out,
    output logic                              hresp_out,
    output logic [CHANNEL_NUM-1:0]            sel_data,
    output logic                              sel_err
);

    dphase_state_e                 state_q, state_d;
    logic [CHANNEL_NUM-1:0]        sel_data_q, sel_data_d;
    logic [CHANNEL_NUM-1:0][1:0]   slv_rsp;
    logic [1:0]                    slv_rsp_sel;
    logic [PAYLOAD-1:0]            slv_payload;
    logic [PAYLOAD-1:0]            payload_d;
    logic                          hready_d;
    logic                          hresp_d;
    logic                          addr_onehot;

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_rsp
        assign slv_rsp[i] = {hreadyout_in[i], hresp_in[i]};
    end

    ahb_onehot_mux #(.CHANNEL_NUM(CHANNEL_NUM), .WIDTH(PAYLOAD)) u_payload_mux (
        .sel_i  (sel_data_q),
        .data_i (payload_in),
        .data_o (slv_payload)
    );

    ahb_onehot_mux #(.CHANNEL_NUM(CHANNEL_NUM), .WIDTH(2)) u_rsp_mux (
        .sel_i  (sel_data_q),
        .data_i (slv_rsp),
        .data_o (slv_rsp_sel)
    );

    assign addr_onehot = is_onehot(32'(sel_addr), CHANNEL_NUM);
    assign sel_data    = sel_data_q;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= D_IDLE;
            sel_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_data_q <= sel_data_d;
        end
    end

    always_comb begin
        payload_d  = '0;
        hready_d   = 1'b1;
        hresp_d    = HRESP_OKAY;
        state_d    = state_q;
        sel_data_d = sel_data_q;
        sel_err    = 1'b0;

        unique case (state_q)
            D_SLV: begin
                payload_d = slv_payload;
                hready_d  = slv_rsp_sel[1];
                hresp_d   = slv_rsp_sel[0];
            end
            D_ERR1: begin
                hready_d = 1'b0;
                hresp_d  = HRESP_ERROR;
            end
            D_ERR2: begin
                hresp_d = HRESP_ERROR;
            end
            default: ;
        endcase

        // A new address phase is taken only when the current data phase completes.
        if (state_q == D_ERR1) begin
            state_d = D_ERR2;
        end else if (hready_in && hready_d) begin
            if (!htrans_valid) begin
                state_d    = D_IDLE;
                sel_data_d = '0;
            end else if (addr_onehot) begin
                state_d    = D_SLV;
                sel_data_d = sel_addr;
            end else begin
                state_d    = D_ERR1;
                sel_data_d = '0;
                sel_err    = !hreset;
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [PAYLOAD-1:0] payload_q;
        logic               hready_q;
        logic               hresp_q;

        always_ff @(posedge hclk) begin
            if (hreset) begin
                payload_q <= '0;
                hready_q  <= 1'b1;
                hresp_q   <= HRESP_OKAY;
            end else begin
                payload_q <= payload_d;
                hready_q  <= hready_d;
                hresp_q   <= hresp_d;
            end
        end

        assign payload_out = payload_q;
        assign hready_out  = hready_q;
        assign hresp_out   = hresp_q;
    end else begin : g_comb_out
        assign payload_out = payload_d;
        assign hready_out  = hready_d;
        assign hresp_out   = hresp_d;
    end

endmodule

// File: tb/tb_ahb_dphase_mux.sv
// Bench for ahb_dphase_mux: a transfer-ownership model checks a combinational-output
// and a registered-output instance every cycle, alongside directed literal checks.
module tb_ahb_dphase_mux;

    localparam int N = 4;
    localparam int W = 34;

    logic                clk = 1'b0;
    logic                hreset;
    logic                hready_in;
    logic                htrans_valid;
    logic [N-1:0]        sel_addr;
    logic [N-1:0][W-1:0] payload_in;
    logic [N-1:0]        hreadyout_in;
    logic [N-1:0]        hresp_in;

    logic [W-1:0] p0, p1;
    logic         r0, r1, e0, e1, se0, se1;
    logic [N-1:0] sd0, sd1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahb_dphase_mux #(.CHANNEL_NUM(N), .PAYLOAD(W), .REG_OUT(0)) u0 (
        .hclk(clk), .hreset(hreset), .hready_in(hready_in), .htrans_valid(htrans_valid),
        .sel_addr(sel_addr), .payload_in(payload_in), .hreadyout_in(hreadyout_in),
        .hresp_in(hresp_in), .payload_out(p0), .hready_out(r0), .hresp_out(e0),
        .sel_data(sd0), .sel_err(se0)
    );

    ahb_dphase_mux #(.CHANNEL_NUM(N), .PAYLOAD(W), .REG_OUT(1)) u1 (
        .hclk(clk), .hreset(hreset), .hready_in(hready_in), .htrans_valid(htrans_valid),
        .sel_addr(sel_addr), .payload_in(payload_in), .hreadyout_in(hreadyout_in),
        .hresp_in(hresp_in), .payload_out(p1), .hready_out(r1), .hresp_out(e1),
        .sel_data(sd1), .sel_err(se1)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the data phase (-1 = nobody) and how far into an error response we are.
    int           owner = -1;
    int           errph = 0;
    bit           mvalid = 0;
    logic [W-1:0] m_pay, rp;
    logic         m_rdy, m_resp, m_se, rr, re;
    logic [N-1:0] m_sd;

    always_comb begin
        m_pay  = '0;
        m_rdy  = 1'b1;
        m_resp = 1'b0;
        m_sd   = '0;
        if (errph == 1) begin
            m_rdy  = 1'b0;
            m_resp = 1'b1;
        end else if (errph == 2) begin
            m_resp = 1'b1;
        end else if (owner >= 0) begin
            m_pay  = payload_in[owner];
            m_rdy  = hreadyout_in[owner];
            m_resp = hresp_in[owner];
            m_sd   = N'(1 << owner);
        end
        m_se = !hreset && hready_in && m_rdy && htrans_valid && ($countones(sel_addr) != 1);
    end

    always @(posedge clk) begin
        if (hreset) begin
            owner = -1; errph = 0;
            rp = '0; rr = 1'b1; re = 1'b0;
            mvalid = 1;
        end else begin
            rp = m_pay; rr = m_rdy; re = m_resp;
            if (errph == 1) begin
                errph = 2;
            end else if (hready_in && m_rdy) begin
                errph = 0;
                owner = -1;
                if (htrans_valid) begin
                    if ($countones(sel_addr) == 1) begin
                        for (int i = 0; i < N; i++) if (sel_addr[i]) owner = i;
                    end else begin
                        errph = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("m_pay",   p0,  m_pay);
            chk("m_rdy",   W'(r0),  W'(m_rdy));
            chk("m_resp",  W'(e0),  W'(m_resp));
            chk("m_sel",   W'(sd0), W'(m_sd));
            chk("m_err",   W'(se0), W'(m_se));
            chk("mr_pay",  p1,  rp);
            chk("mr_rdy",  W'(r1),  W'(rr));
            chk("mr_resp", W'(e1),  W'(re));
            chk("mr_sel",  W'(sd1), W'(m_sd));
            chk("mr_err",  W'(se1), W'(m_se));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        hready_in    = 1'b1;
        htrans_valid = 1'b0;
        sel_addr     = '0;
        hreadyout_in = '1;
        hresp_in     = '0;
    endtask

    task automatic set_pay();
        for (int i = 0; i < N; i++) payload_in[i] = {2'(i), 32'hC0DE_0000 | 32'(i)};
        payload_in[2] = 34'h2_DEAD_BEEF;
    endtask

    logic [N-1:0] pats [2] = '{4'b0000, 4'b0110};

    initial begin
        hreset = 1'b1;
        idle_in();
        set_pay();
        nxt();
        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            sel_addr     = N'($urandom);
            htrans_valid = 1'($urandom);
            hready_in    = 1'($urandom);
            hreadyout_in = N'($urandom);
            hresp_in     = N'($urandom);
            for (int i = 0; i < N; i++) payload_in[i] = {2'($urandom), 32'($urandom)};
            @(negedge clk);
            chk("rst_pay",   p0, '0);
            chk("rst_rdy",   W'(r0), 1);
            chk("rst_resp",  W'(e0), 0);
            chk("rst_sel",   W'(sd0), 0);
            chk("rst_err",   W'(se0), 0);
            chk("rst_pay_r", p1, '0);
            chk("rst_rdy_r", W'(r1), 1);
            nxt();
        end
        hreset = 1'b0;
        idle_in();
        set_pay();

        // Zero-wait read from channel 2
        htrans_valid = 1'b1; sel_addr = 4'b0100;
        @(negedge clk); chk("s2_addr_err", W'(se0), 0);
        nxt();
        htrans_valid = 1'b0; sel_addr = '0;
        @(negedge clk);
        chk("s2_pay", p0, 34'h2_DEAD_BEEF);
        chk("s2_rdy", W'(r0), 1);
        chk("s2_sel", W'(sd0), 4'b0100);
        nxt();
        @(negedge clk);
        chk("s2_pay_reg", p1, 34'h2_DEAD_BEEF);
        chk("s2_idle_pay", p0, '0);
        nxt();

        // Wait states on channel 1 while the next address targets channel 3
        htrans_valid = 1'b1; sel_addr = 4'b0010;
        nxt();
        sel_addr = 4'b1000; hreadyout_in[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s3_hold_sel", W'(sd0), 4'b0010);
            chk("s3_hold_rdy", W'(r0), 0);
            nxt();
        end
        hreadyout_in[1] = 1'b1;
        @(negedge clk);
        chk("s3_done_rdy", W'(r0), 1);
        chk("s3_done_pay", p0, 34'h1_C0DE_0001);
        nxt();
        htrans_valid = 1'b0; sel_addr = '0;
        @(negedge clk);
        chk("s3_ch3_sel", W'(sd0), 4'b1000);
        chk("s3_ch3_pay", p0, 34'h3_C0DE_0003);
        nxt();

        // hready_in low: address phase ignored
        hready_in = 1'b0; htrans_valid = 1'b1; sel_addr = 4'b0001;
        nxt();
        idle_in();
        @(negedge clk); chk("hold_sel", W'(sd0), 0);
        nxt();

        // Unmapped and multi-hot selects
        for (int k = 0; k < 2; k++) begin
            htrans_valid = 1'b1; sel_addr = pats[k];
            @(negedge clk); chk("s4_err_pulse", W'(se0), 1);
            nxt();
            idle_in();
            @(negedge clk);
            chk("s4_e1_rdy", W'(r0), 0); chk("s4_e1_resp", W'(e0), 1); chk("s4_e1_err", W'(se0), 0);
            nxt();
            @(negedge clk);
            chk("s4_e2_rdy", W'(r0), 1); chk("s4_e2_resp", W'(e0), 1);
            chk("s4_e1_rdy_r", W'(r1), 0); chk("s4_e1_resp_r", W'(e1), 1);
            nxt();
            @(negedge clk);
            chk("s4_ok_rdy", W'(r0), 1); chk("s4_ok_resp", W'(e0), 0);
            chk("s4_e2_rdy_r", W'(r1), 1); chk("s4_e2_resp_r", W'(e1), 1);
            nxt();
        end

        // Back-to-back: error then channel 0 accepted in D_ERR2
        htrans_valid = 1'b1; sel_addr = 4'b0000;
        @(negedge clk); chk("s5_err_pulse", W'(se0), 1);
        nxt();
        sel_addr = 4'b0001;
        @(negedge clk); chk("s5_e1_err", W'(se0), 0); chk("s5_e1_rdy", W'(r0), 0);
        nxt();
        @(negedge clk); chk("s5_e2_rdy", W'(r0), 1); chk("s5_e2_resp", W'(e0), 1);
        nxt();
        htrans_valid = 1'b0; sel_addr = '0;
        @(negedge clk);
        chk("s5_ch0_sel", W'(sd0), 4'b0001);
        chk("s5_ch0_pay", p0, 34'h0_C0DE_0000);
        chk("s5_ch0_resp", W'(e0), 0);
        nxt();
        @(negedge clk); chk("s5_idle_rdy", W'(r0), 1); chk("s5_idle_sel", W'(sd0), 0);
        nxt();

        // Reset during D_ERR1
        htrans_valid = 1'b1; sel_addr = 4'b1111;
        @(negedge clk); chk("s6_err_pulse", W'(se0), 1);
        nxt();
        hreset = 1'b1; idle_in();
        @(negedge clk); chk("s6_e1_rdy", W'(r0), 0); chk("s6_e1_resp", W'(e0), 1);
        nxt();
        htrans_valid = 1'b1; sel_addr = 4'b0000;
        @(negedge clk);
        chk("s6_rst_rdy", W'(r0), 1); chk("s6_rst_resp", W'(e0), 0);
        chk("s6_rst_err", W'(se0), 0);
        chk("s6_rst_rdy_r", W'(r1), 1); chk("s6_rst_resp_r", W'(e1), 0);
        nxt();
        hreset = 1'b0; idle_in();

        // Slave-driven ERROR passes straight through
        htrans_valid = 1'b1; sel_addr = 4'b0001;
        nxt();
        idle_in(); hreadyout_in[0] = 1'b0; hresp_in[0] = 1'b1;
        @(negedge clk); chk("sx_e1_rdy", W'(r0), 0); chk("sx_e1_resp", W'(e0), 1);
        nxt();
        hreadyout_in[0] = 1'b1;
        @(negedge clk); chk("sx_e2_rdy", W'(r0), 1); chk("sx_e2_resp", W'(e0), 1);
        nxt();
        idle_in();
        nxt();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_dphase_mux.md
Name: ahb_dphase_mux

Overview:
Parametrised AHB response/read-data multiplexer with address-to-data-phase select tracking and a built-in default slave. It samples the decoder's one-hot address-phase select on each accepted transfer, holds it through the data phase (including wait states), and routes the selected channel's payload, HREADYOUT and HRESP back to the master. Unmapped or multi-hot selects get the AHB two-cycle ERROR response from the internal default slave. It sits between the slave-side channels and the master port of each interconnect layer, replacing the purely combinational select-mux.

Parameters:
CHANNEL_NUM, 4, number of slave channels (1..32)
PAYLOAD, 34, width of each channel's read-data payload in bits
REG_OUT, 0, 1 = payload_out/hresp_out/hready_out registered (adds 1 cycle), 0 = combinational from data-phase select

Ports:
hclk  in  1  AHB clock
hreset  in  1  synchronous reset, active-high
hready_in  in  1  bus HREADY; address phase is accepted when 1
htrans_valid  in  1  address phase carries NONSEQ/SEQ (0 = IDLE/BUSY)
sel_addr  in  CHANNEL_NUM  one-hot decoder select, address phase
payload_in  in  CHANNEL_NUM x PAYLOAD  per-channel read data
hreadyout_in  in  CHANNEL_NUM  per-channel HREADYOUT
hresp_in  in  CHANNEL_NUM  per-channel HRESP (1 = ERROR)
payload_out  out  PAYLOAD  muxed read data
hready_out  out  1  muxed HREADY to master
hresp_out  out  1  muxed HRESP
sel_data  out  CHANNEL_NUM  registered data-phase select
sel_err  out  1  one-cycle pulse: illegal select accepted

Behaviour:
- Reset: sel_data=0, FSM=D_IDLE, payload_out=0, hready_out=1, hresp_out=0, sel_err=0. Any in-flight transfer is dropped; no ERROR completes.
- FSM states: D_IDLE (no transfer in data phase), D_SLV (slave channel owns the data phase), D_ERR1, D_ERR2 (default-slave error).
- Acceptance: the address phase is sampled only when hready_in=1. When hready_in=0, sel_data and state hold.
- On acceptance:
  - htrans_valid=0 -> D_IDLE, sel_data=0.
  - htrans_valid=1 with sel_addr exactly one-hot -> D_SLV, sel_data=sel_addr.
  - htrans_valid=1 with sel_addr zero or multi-hot -> D_ERR1, sel_data=0, sel_err=1 for that cycle.
- D_IDLE outputs: payload_out=0, hready_out=1, hresp_out=0 (zero-wait OKAY).
- D_SLV outputs: payload_out, hready_out and hresp_out come from the channel selected by sel_data. The data phase ends on the cycle hready_out=1; the next address phase is evaluated in that same cycle.
- D_ERR1: hready_out=0, hresp_out=1, payload_out=0. Always goes to D_ERR2 next cycle.
- D_ERR2: hready_out=1, hresp_out=1, payload_out=0. The address phase is evaluated as normal (back-to-back errors allowed).
- Slave ERROR passthrough: no special handling; the slave drives its own two-cycle sequence through the mux.
- CHANNEL_NUM=1: sel_addr=0 is still an error; sel_addr=1 is legal.
- REG_OUT=1: all three outputs are delayed exactly 1 cycle. The reset values above apply to the registered outputs.
- sel_err is never asserted in the same cycle as hreset.

Decomposition:
- AHB_package gains:
  - typedef enum dphase_state_e {D_IDLE, D_SLV, D_ERR1, D_ERR2};
  - localparams HRESP_OKAY=1'b0 and HRESP_ERROR=1'b1;
  - function is_onehot(logic [31:0] v, int n).
- One combinational sub-module, ahb_onehot_mux (CHANNEL_NUM, WIDTH), handles data selection. It is instantiated once for payload and once for the packed {hreadyout, hresp} pair, and outputs 0 when the select is not one-hot.

Test Plan:
1. Reset held 3 cycles, inputs random -> payload_out=0, hready_out=1, hresp_out=0, sel_data=0, sel_err=0 throughout.
2. Zero-wait read: htrans_valid=1, sel_addr=4'b0100, hready_in=1; next cycle payload_in[2]=34'h2_DEAD_BEEF, hreadyout_in[2]=1 -> payload_out=34'h2_DEAD_BEEF, hready_out=1, sel_data=4'b0100.
3. Wait states: channel 1 holds hreadyout_in[1]=0 for 3 cycles while sel_addr changes to 4'b1000 -> sel_data stays 4'b0010 and hready_out=0 for 3 cycles; channel 3 is selected only after hreadyout_in[1]=1.
4. Unmapped: sel_addr=4'b0000 with htrans_valid=1 -> sel_err pulse, then hready_out/hresp_out = 0/1, then 1/1, then idle OKAY. Repeat with sel_addr=4'b0110 and expect the same response.
5. Back-to-back: error in D_ERR2 accepts a new transfer to channel 0 -> D_SLV in the following cycle with no bubble. An IDLE transfer (htrans_valid=0) gives zero-wait OKAY.
6. Reset mid-D_ERR1 -> next cycle D_IDLE outputs (hready_out=1, hresp_out=0). Repeat scenarios 2 and 4 with REG_OUT=1 and check the identical sequence shifted by one cycle.
